// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC writeback stage.
package npc_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wbu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/write_back_unit_if.sv
// Writeback bus: EXU retire handshake, LSU read return, register file port and commit.
// Handshake: an EXU result moves when exu_valid && exu_ready are both high on a
// rising clk edge; exu_valid may be held across cycles, exu_ready depends only on
// WBU state. lsu_rvalid is a one-cycle pulse with no back-pressure.
interface write_back_unit_if #(parameter int XLEN = npc_pkg::XLEN_DEF);
  logic            exu_valid;
  logic            exu_ready;
  logic [4:0]      exu_rd;
  logic [XLEN-1:0] exu_result;
  logic [XLEN-1:0] exu_pc;
  logic            exu_is_load;
  logic [2:0]      exu_funct3;
  logic [1:0]      exu_addr_lo;
  logic            lsu_rvalid;
  logic [XLEN-1:0] lsu_rdata;
  logic            rf_wen;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            wb_err;

  // Pipeline side (EXU/LSU producers, register file consumer)
  modport master (
    output exu_valid, exu_rd, exu_result, exu_pc, exu_is_load, exu_funct3,
           exu_addr_lo, lsu_rvalid, lsu_rdata,
    input  exu_ready, rf_wen, rf_rd, rf_wdata, commit_valid, commit_pc, wb_err
  );

  // Writeback unit side
  modport slave (
    input  exu_valid, exu_rd, exu_result, exu_pc, exu_is_load, exu_funct3,
           exu_addr_lo, lsu_rvalid, lsu_rdata,
    output exu_ready, rf_wen, rf_rd, rf_wdata, commit_valid, commit_pc, wb_err
  );
endinterface

// File: rtl/write_back_unit_load_extend.sv
// Load data lane select and sign/zero extension (combinational).
module load_extend
  import npc_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword; addr_lo[0] is ignored for halves.
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Extend by load type; word and unknown encodings pass the full word.
  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/write_back_unit.sv
// NPC writeback stage: ALU results retire one cycle after transfer, loads one
// cycle after the LSU read pulse. Optional load timeout: WBU_LOAD_TIMEOUT_EN.
module write_back_unit
  import npc_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  write_back_unit_if.slave   bus,
  output wbu_state_e         o_dbg_state
);

  wbu_state_e      r_state, w_next;
  logic            w_ready, w_xfer, w_timeout, w_latch, w_err_set;
  logic            w_wen_d, w_commit_d;
  logic [4:0]      w_rd_d;
  logic [XLEN-1:0] w_wdata_d, w_pc_d, w_ext;

  logic            r_rf_wen, r_commit_valid, r_wb_err;
  logic [4:0]      r_rf_rd;
  logic [XLEN-1:0] r_rf_wdata, r_commit_pc;

  // Pending load context captured at transfer
  logic [4:0]      r_ld_rd;
  logic [XLEN-1:0] r_ld_pc;
  logic [2:0]      r_ld_f3;
  logic [1:0]      r_ld_alo;

  load_extend #(.XLEN(XLEN)) u_ext (
    .i_rdata   (bus.lsu_rdata),
    .i_funct3  (r_ld_f3),
    .i_addr_lo (r_ld_alo),
    .o_data    (w_ext)
  );

`ifdef WBU_LOAD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  // Count WAIT_MEM cycles that pass without read data; cleared on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     r_cnt <= '0;
    else if (w_latch)                               r_cnt <= '0;
    else if (r_state == WAIT_MEM && !bus.lsu_rvalid) r_cnt <= r_cnt + 1'b1;
  end

  // The cycle whose miss would make the count reach the limit gives up.
  assign w_timeout = (r_state == WAIT_MEM) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
  assign w_timeout    = 1'b0;
`endif

  assign w_ready = (r_state == IDLE) || (r_state == WRITE);
  assign w_xfer  = bus.exu_valid && w_ready;

  // Next state and next registered output values
  always_comb begin
    w_next     = r_state;
    w_wen_d    = 1'b0;
    w_commit_d = 1'b0;
    w_rd_d     = r_rf_rd;
    w_wdata_d  = r_rf_wdata;
    w_pc_d     = r_commit_pc;
    w_latch    = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      IDLE, WRITE: begin
        if (w_xfer && !bus.exu_is_load) begin
          w_next     = WRITE;
          w_wen_d    = (bus.exu_rd != 5'd0);
          w_commit_d = 1'b1;
          w_rd_d     = bus.exu_rd;
          w_wdata_d  = bus.exu_result;
          w_pc_d     = bus.exu_pc;
        end else if (w_xfer) begin
          w_next  = WAIT_MEM;
          w_latch = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      WAIT_MEM: begin
        if (bus.lsu_rvalid) begin
          w_next     = WRITE;
          w_wen_d    = (r_ld_rd != 5'd0);
          w_commit_d = 1'b1;
          w_rd_d     = r_ld_rd;
          w_wdata_d  = w_ext;
          w_pc_d     = r_ld_pc;
        end else if (w_timeout) begin
          w_next     = WRITE;
          w_commit_d = 1'b1;
          w_rd_d     = r_ld_rd;
          w_wdata_d  = '0;
          w_pc_d     = r_ld_pc;
          w_err_set  = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Registered writeback outputs and pending-load context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_wen       <= 1'b0;
      r_commit_valid <= 1'b0;
      r_rf_rd        <= '0;
      r_rf_wdata     <= '0;
      r_commit_pc    <= '0;
      r_wb_err       <= 1'b0;
      r_ld_rd        <= '0;
      r_ld_pc        <= '0;
      r_ld_f3        <= '0;
      r_ld_alo       <= '0;
    end else begin
      r_rf_wen       <= w_wen_d;
      r_commit_valid <= w_commit_d;
      r_rf_rd        <= w_rd_d;
      r_rf_wdata     <= w_wdata_d;
      r_commit_pc    <= w_pc_d;
      if (w_err_set) r_wb_err <= 1'b1;
      if (w_latch) begin
        r_ld_rd  <= bus.exu_rd;
        r_ld_pc  <= bus.exu_pc;
        r_ld_f3  <= bus.exu_funct3;
        r_ld_alo <= bus.exu_addr_lo;
      end
    end
  end

  assign bus.exu_ready    = w_ready;
  assign bus.rf_wen       = r_rf_wen;
  assign bus.rf_rd        = r_rf_rd;
  assign bus.rf_wdata     = r_rf_wdata;
  assign bus.commit_valid = r_commit_valid;
  assign bus.commit_pc    = r_commit_pc;
  assign bus.wb_err       = r_wb_err;
  assign o_dbg_state      = r_state;

endmodule
